// File: rtl/rc4_sched_pkg.sv
// Shared constants and FSM state type for the RC4 key-space scheduler and core wrappers.
package rc4_sched_pkg;
  localparam int SCHED_KEY_W      = 24;
  localparam int SCHED_CHUNK_LOG2 = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a rotating pointer that moves past the winner on accept.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         accept,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  int            idx;

  always_comb begin
    gnt  = '0;
    any  = 1'b0;
    pick = '0;
    idx  = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        pick     = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (clear)  ptr <= '0;
    else if (accept) ptr <= (int'(pick) == N - 1) ? '0 : pick + 1'b1;
  end
endmodule

// File: rtl/rc4_key_scheduler.sv
// Hands fixed-size key chunks to idle RC4 cores, latches the first hit and reports exhaustion.
// Optional RC4_SCHED_PERF_EN adds search-cycle and dispatched-chunk counters.
module rc4_key_scheduler
  import rc4_sched_pkg::*;
#(
  parameter int               NUM_CORES  = 4,
  parameter int               KEY_W      = SCHED_KEY_W,
  parameter logic [KEY_W-1:0] KEY_MAX    = 24'h3FFFFF,
  parameter int               CHUNK_LOG2 = SCHED_CHUNK_LOG2
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_req,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]       grant,
  output logic [KEY_W-1:0]           chunk_base,
  output logic [KEY_W-1:0]           chunk_last,
  output logic                       stop,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       exhausted,
  output logic                       busy,
  output logic [31:0]                perf_cycles,
  output logic [15:0]                perf_chunks
);
  localparam int             BW      = KEY_W + 1;
  localparam logic [BW-1:0]  CHUNK   = {{(BW-1){1'b0}}, 1'b1} << CHUNK_LOG2;
  localparam logic [BW-1:0]  MAX_EXT = {1'b0, KEY_MAX};

  sched_state_t         state;
  logic [BW-1:0]        next_base, base_end;
  logic [KEY_W-1:0]     last_clip, win_key;
  logic [NUM_CORES-1:0] active, req_q, req_rise, eligible, arb_gnt;
  logic                 arb_any, start_go, do_grant, any_found, range_done;

  assign base_end   = next_base + CHUNK - 1'b1;
  assign last_clip  = (base_end > MAX_EXT) ? KEY_MAX : base_end[KEY_W-1:0];
  assign range_done = next_base > MAX_EXT;
  assign any_found  = |core_found;
  // A rising req on an active core means its chunk finished; it may be re-granted the same edge.
  assign req_rise   = core_req & ~req_q & active;
  assign eligible   = core_req & (~active | req_rise);
  assign start_go   = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);
  assign do_grant   = (state == S_SEARCH) && !any_found && !range_done && arb_any;

  always_comb begin
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (core_found[i]) win_key = core_key[i*KEY_W +: KEY_W];
  end

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .clear  (start_go),
    .accept (do_grant),
    .req    (eligible),
    .gnt    (arb_gnt),
    .any    (arb_any)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      next_base  <= '0;
      active     <= '0;
      req_q      <= '0;
      grant      <= '0;
      chunk_base <= '0;
      chunk_last <= '0;
      stop       <= 1'b0;
      found      <= 1'b0;
      found_key  <= '0;
      exhausted  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      grant  <= '0;
      req_q  <= core_req;
      active <= (active & ~req_rise) | (do_grant ? arb_gnt : '0);
      case (state)
        S_SEARCH: begin
          if (any_found) begin
            state     <= S_FOUND;
            found     <= 1'b1;
            stop      <= 1'b1;
            found_key <= win_key;
            busy      <= 1'b0;
          end else if (range_done) begin
            state <= S_DRAIN;
          end else if (do_grant) begin
            grant      <= arb_gnt;
            chunk_base <= next_base[KEY_W-1:0];
            chunk_last <= last_clip;
            next_base  <= next_base + CHUNK;
          end
        end
        S_DRAIN: begin
          if (any_found) begin
            state     <= S_FOUND;
            found     <= 1'b1;
            stop      <= 1'b1;
            found_key <= win_key;
            busy      <= 1'b0;
          end else if (active == '0) begin
            state     <= S_EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          if (start_go) begin
            state     <= S_SEARCH;
            next_base <= '0;
            active    <= '0;
            stop      <= 1'b0;
            found     <= 1'b0;
            found_key <= '0;
            exhausted <= 1'b0;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef RC4_SCHED_PERF_EN
  logic [31:0] cyc_cnt;
  logic [15:0] chunk_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt   <= '0;
      chunk_cnt <= '0;
    end else if (start_go) begin
      cyc_cnt   <= '0;
      chunk_cnt <= '0;
    end else begin
      if (busy) cyc_cnt <= cyc_cnt + 1'b1;
      if (do_grant && chunk_cnt != 16'hFFFF) chunk_cnt <= chunk_cnt + 1'b1;
    end
  end

  assign perf_cycles = cyc_cnt;
  assign perf_chunks = chunk_cnt;
`else
  assign perf_cycles = '0;
  assign perf_chunks = '0;
`endif
endmodule
